// File: rtl/i2s_frame_rx.sv
// i2s_frame_rx
//   Front end of the audio path. Samples LRCK and SDATA on rising bck,
//   deserialises each LRCK slot MSB-first into DATA_W-bit words and pairs
//   them into left/right stereo samples. Produces a registered one-cycle
//   lrck_changed strobe that a downstream bck halver samples on falling bck.
//   Output stays quiet (no capture, commit or error) until the first LRCK
//   edge after reset.
//
// Parameters
//   DATA_W      captured bits per slot (1..32); later slot bits are ignored
//   I2S_DELAY   1 = I2S (MSB one bck after the LRCK edge), 0 = left-justified
//   LEFT_LEVEL  LRCK level that marks the left slot
//
// Ports
//   bck           in   bit clock, all state changes on its rising edge
//   rst_n         in   asynchronous active-low reset
//   lrck          in   frame sync
//   sdata         in   serial data
//   lrck_changed  out  one-cycle strobe after a detected LRCK transition
//   left_data     out  last committed left word, held
//   right_data    out  last committed right word, held
//   sample_valid  out  one-cycle strobe: a new left+right pair is on the outputs
//   short_err     out  one-cycle strobe: a slot ended before DATA_W bits arrived
//   locked        out  high once the first LRCK edge after reset has been seen
module i2s_frame_rx #(
  parameter int DATA_W     = 16,
  parameter int I2S_DELAY  = 1,
  parameter int LEFT_LEVEL = 0
) (
  input  logic              bck,
  input  logic              rst_n,
  input  logic              lrck,
  input  logic              sdata,
  output logic              lrck_changed,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              short_err,
  output logic              locked
);

  localparam logic [5:0] FIRST_IDX = 6'(I2S_DELAY);
  localparam logic [5:0] LAST_IDX  = 6'(DATA_W - 1);
  localparam logic [5:0] WORD_BITS = 6'(DATA_W);
  localparam logic [5:0] FULL_CNT  = 6'(DATA_W + I2S_DELAY);
  localparam logic       LEFT_LVL  = (LEFT_LEVEL != 0);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              lrck_p0;
  logic              armed;
  logic [5:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              left_seen;

  logic              change;
  logic              run_now;
  logic [5:0]        cnt_eff;
  logic [5:0]        slot_idx;
  logic              capture;
  logic              commit;
  logic              commit_left;
  logic              commit_right;
  logic              short_det;
  logic [DATA_W-1:0] shift_base;
  logic [DATA_W-1:0] shift_nxt;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  // Stage p0 inputs: edge detect and slot bookkeeping, evaluated against the
  // registered previous LRCK sample.
  always_comb begin
    change     = armed & (lrck ^ lrck_p0);
    // The detecting posedge is count 0 of the new slot, so with no delay it
    // already carries the new slot's MSB.
    cnt_eff    = change ? 6'd0 : bit_cnt;
    // Index wraps to a large value while still inside the delay, which the
    // range check below rejects.
    slot_idx   = cnt_eff - FIRST_IDX;
    // The posedge that moves SYNC->RUN already belongs to the first real slot.
    run_now    = (state == RUN) | change;
    capture    = run_now & (slot_idx < WORD_BITS);
    commit     = capture & (slot_idx == LAST_IDX);
    // Current lrck equals the slot level on every commit posedge, including
    // the single-bit left-justified case where commit lands on the edge.
    commit_left  = commit & (lrck == LEFT_LVL);
    commit_right = commit & (lrck != LEFT_LVL);
    // bit_cnt holds the length of the slot that is ending; a slot shorter
    // than delay + DATA_W never reached its commit posedge.
    short_det  = change & (state == RUN) & (bit_cnt < FULL_CNT);
    shift_base = change ? '0 : shift;
    shift_nxt  = (shift_base << 1) | DATA_W'(sdata);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (change) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = SYNC;
    endcase
  end

  // Stage p0 -> outputs: every register updates on the same posedge, so all
  // strobes and data words become visible one bck after the sampling edge.
  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      armed        <= 1'b0;
      bit_cnt      <= 6'd0;
      shift        <= '0;
      left_seen    <= 1'b0;
      lrck_changed <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      short_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      // lrck_p0 is deliberately left out of the reset branch: it simply holds
      // during reset and armed masks its first comparison afterwards.
      lrck_p0      <= lrck;
      armed        <= 1'b1;
      state        <= state_nxt;
      locked       <= (state_nxt == RUN);
      lrck_changed <= change;
      bit_cnt      <= sat_inc(cnt_eff);
      short_err    <= short_det;
      sample_valid <= commit_right & left_seen;

      if (capture) begin
        shift <= shift_nxt;
      end else if (change) begin
        shift <= '0;
      end

      if (commit_left) begin
        left_data <= shift_nxt;
      end
      if (commit_right) begin
        right_data <= shift_nxt;
      end

      if (commit_left) begin
        left_seen <= 1'b1;
      end else if (commit_right | short_det) begin
        left_seen <= 1'b0;
      end
    end
  end

endmodule
